// File: rtl/filter_align_ctrl_5x5_if.sv
// rtl/filter_align_ctrl_5x5_if.sv - stream/line-memory signal bundle for the 5x5 aligner sequencer
//
// Purpose: groups the frame/pixel inputs and the line-memory control outputs of
// filter_align_ctrl_5x5 so they travel as one port.
// Signals:
//   vs, de, hsize, vsize                       frame start, pixel valid, latched frame sizes
//   mem_ren, mem_sel, mem_waddr, mem_raddr     line-memory control
//   pad_y                                      top/bottom padding flags for the current output row
//   busy, frame_done, err                      frame status
// Modports: master drives the stream (source/bench), slave is the sequencer.

interface filter_align_ctrl_5x5_if #(
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int V_CNT_WIDTH    = 11
);
    logic                      vs;
    logic                      de;
    logic [MEM_ADDR_WIDTH:0]   hsize;
    logic [V_CNT_WIDTH-1:0]    vsize;
    logic                      mem_ren;
    logic [1:0]                mem_sel;
    logic [MEM_ADDR_WIDTH-1:0] mem_waddr;
    logic [MEM_ADDR_WIDTH-1:0] mem_raddr;
    logic [3:0]                pad_y;
    logic                      busy;
    logic                      frame_done;
    logic                      err;

    modport master (
        output vs, de, hsize, vsize,
        input  mem_ren, mem_sel, mem_waddr, mem_raddr, pad_y, busy, frame_done, err
    );

    modport slave (
        input  vs, de, hsize, vsize,
        output mem_ren, mem_sel, mem_waddr, mem_raddr, pad_y, busy, frame_done, err
    );
endinterface

// File: rtl/filter_align_ctrl_5x5.sv
// rtl/filter_align_ctrl_5x5.sv - line/pixel sequencer for the 5x5 line-buffer aligner
//
// Purpose: tracks pixel and line position of the live stream, generates line-memory
// read/write addresses, ring select and vertical padding flags, and after the last
// input line runs two internal flush lines so every output row is emitted
// (output row r = input row r+2).
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high
//   bus   filter_align_ctrl_5x5_if.slave (stream inputs, line-memory controls, status)

module filter_align_ctrl_5x5 #(
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int V_CNT_WIDTH    = 11,
    parameter int FLUSH_GAP      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    filter_align_ctrl_5x5_if.slave  bus
);
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int VW = V_CNT_WIDTH;
    localparam int GW = $clog2(FLUSH_GAP + 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_GAP, S_FLUSH} state_t;

    state_t         state;
    logic [AW:0]    hsize_q;
    logic [VW-1:0]  vsize_q;
    logic [AW-1:0]  cnt;        // pixel position; saturates at hsize-1
    logic           full_q;     // pixel hsize-1 already consumed in this line
    logic [VW:0]    line;       // one extra bit: counts through vsize+2 flush lines
    logic [GW-1:0]  gap_cnt;
    logic           act_d1;
    logic           fall_q;     // line end strobe, one cycle after activity falls
    logic [1:0]     sel_q;
    logic [3:0]     pad_q;
    logic [AW-1:0]  waddr_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;

    logic           live;
    logic           act;
    logic           at_last;
    logic           size_ok;
    logic [VW:0]    line_next;
    logic [VW:0]    vsize_ext;

    // Padding flags of the output row produced while input line l is current (row l-2).
    function automatic logic [3:0] pad_for(input logic [VW:0] l, input logic [VW-1:0] vsz);
        logic [VW:0] r;
        logic [VW:0] v;
        r = l - (VW+1)'(2);
        v = {1'b0, vsz};
        pad_for = 4'b0000;
        if (l >= (VW+1)'(2)) begin
            pad_for[0] = (r == (VW+1)'(0));
            pad_for[1] = (r == (VW+1)'(1));
            pad_for[2] = (r == v - (VW+1)'(1));
            pad_for[3] = (r == v - (VW+1)'(2));
        end
    endfunction

    always_comb begin
        live      = (state == S_FILL) || (state == S_STREAM);
        // Flush lines reuse the live-line counter and line-end logic.
        act       = (live && bus.de) || (state == S_FLUSH);
        at_last   = ({1'b0, cnt} == hsize_q - (AW+1)'(1));
        size_ok   = (bus.vsize >= VW'(3)) && (bus.hsize != '0);
        line_next = line + (VW+1)'(1);
        vsize_ext = {1'b0, vsize_q};
    end

    // Read side is combinational so read data lines up with the aligner's registered pixel.
    assign bus.mem_ren    = ((state == S_STREAM) && bus.de && (line >= (VW+1)'(2))) || (state == S_FLUSH);
    assign bus.mem_raddr  = cnt;
    assign bus.mem_waddr  = waddr_q;
    assign bus.mem_sel    = sel_q;
    assign bus.pad_y      = pad_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.err        = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            hsize_q <= '0;
            vsize_q <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            line    <= '0;
            gap_cnt <= '0;
            act_d1  <= 1'b0;
            fall_q  <= 1'b0;
            sel_q   <= 2'b00;
            pad_q   <= 4'b0000;
            waddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.vs) begin
            // Frame restart wins over everything; a coincident de pixel is px 0 of line 0.
            hsize_q <= bus.hsize;
            vsize_q <= bus.vsize;
            line    <= '0;
            gap_cnt <= '0;
            fall_q  <= 1'b0;
            sel_q   <= 2'b00;
            pad_q   <= 4'b0000;
            waddr_q <= '0;
            done_q  <= 1'b0;
            cnt     <= '0;
            full_q  <= 1'b0;
            if (size_ok) begin
                state  <= S_FILL;
                busy_q <= 1'b1;
                err_q  <= 1'b0;
                act_d1 <= bus.de;
                if (bus.de) begin
                    if (bus.hsize == (AW+1)'(1)) full_q <= 1'b1;
                    else                         cnt    <= AW'(1);
                end
            end else begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
                err_q  <= 1'b1;
                act_d1 <= 1'b0;
            end
        end else begin
            done_q  <= 1'b0;
            act_d1  <= act;
            fall_q  <= act_d1 && !act;
            waddr_q <= (live && bus.de) ? cnt : '0;

            if (bus.de && (!live || full_q))
                err_q <= 1'b1;

            if (act && !full_q) begin
                if (at_last) full_q <= 1'b1;
                else         cnt    <= cnt + AW'(1);
            end

            case (state)
                S_GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (gap_cnt == GW'(FLUSH_GAP - 1))
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (at_last) begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                    end
                end
                default: ;
            endcase

            // Line end lands two cycles after the last active cycle, so sel/pad stay
            // stable while the final reads of the line are still in flight.
            if (fall_q && (state != S_IDLE)) begin
                cnt     <= '0;
                full_q  <= 1'b0;
                gap_cnt <= '0;
                line    <= line_next;
                sel_q   <= line_next[1:0];
                pad_q   <= pad_for(line_next, vsize_q);
                case (state)
                    S_FILL:   if (line_next == (VW+1)'(2)) state <= S_STREAM;
                    S_STREAM: if (line_next == vsize_ext)  state <= S_GAP;
                    S_GAP: begin
                        if (line_next == vsize_ext + (VW+1)'(2)) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
